dcache_read_arbiter: RTL and testbench



---
 rtl/dcache_read_arbiter_if.sv | 42 ++++
 rtl/dcache_read_arbiter.sv | 125 ++++++++++++
 tb/tb_dcache_read_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_read_arbiter_if.sv
// Requester and dcache-side signals of the shared dcache read port.
// master = arbiter side, slave = requesters plus dcache.
interface dcache_read_arbiter_if;
    logic        mem1_req;
    logic [26:0] mem1_addr;
    logic        mem1_gnt;
    logic        mem1_rvalid;
    logic        fe1_req;
    logic [26:0] fe1_addr;
    logic        fe1_gnt;
    logic        fe1_rvalid;
    logic        mem0_req;
    logic        mem0_trans;
    logic [29:0] mem0_addr;
    logic        mem0_gnt;
    logic        mem0_rvalid;
    logic [8:0]  satp_asid;
    logic        dc_read;
    logic        dc_trans;
    logic [8:0]  dc_asid;
    logic [29:0] dc_addr;
    logic        dc_ready;
    logic        dc_rvalid;

    modport master (
        input  mem1_req, mem1_addr, fe1_req, fe1_addr,
        input  mem0_req, mem0_trans, mem0_addr, satp_asid,
        input  dc_ready, dc_rvalid,
        output mem1_gnt, mem1_rvalid, fe1_gnt, fe1_rvalid,
        output mem0_gnt, mem0_rvalid,
        output dc_read, dc_trans, dc_asid, dc_addr
    );

    modport slave (
        output mem1_req, mem1_addr, fe1_req, fe1_addr,
        output mem0_req, mem0_trans, mem0_addr, satp_asid,
        output dc_ready, dc_rvalid,
        input  mem1_gnt, mem1_rvalid, fe1_gnt, fe1_rvalid,
        input  mem0_gnt, mem0_rvalid,
        input  dc_read, dc_trans, dc_asid, dc_addr
    );
endinterface

// File: rtl/dcache_read_arbiter.sv
// Shares the dcache read port between mem1/fe1 walks and mem0 accesses.
// Define DCARB_RR_EN to round-robin between the two walkers.
module dcache_read_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input logic                  clk_core,
    input logic                  reset_n,
    dcache_read_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {
        OWN_NONE, OWN_MEM1, OWN_FE1, OWN_MEM0
    } owner_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    state_t           state;
    owner_t           owner;
    owner_t           winner;
    owner_t           cur;
    logic [CNT_W-1:0] starve_cnt;
    logic             aged;
    logic             issue;
    logic             accept;
    logic             resp;
    logic             own_req;
    logic             rr_ptr;

    assign aged = (STARVE_LIMIT != 0) && (starve_cnt >= LIMIT);

`ifdef DCARB_RR_EN
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= 1'b0;
        else if (accept && (cur == OWN_MEM1 || cur == OWN_FE1))
            rr_ptr <= ~rr_ptr;
    end
`else
    assign rr_ptr = 1'b0;
`endif

    // rr_ptr=1 hands the shared walker slot to fe1 when both ask
    always_comb begin
        priority case (1'b1)
            aged && bus.mem0_req:                   winner = OWN_MEM0;
            bus.mem1_req && !(rr_ptr && bus.fe1_req): winner = OWN_MEM1;
            bus.fe1_req:                            winner = OWN_FE1;
            bus.mem0_req:                           winner = OWN_MEM0;
            default:                                winner = OWN_NONE;
        endcase
    end

    assign cur    = (state == IDLE) ? winner : owner;
    assign issue  = reset_n && (state != WAIT) && (cur != OWN_NONE);
    assign accept = issue && bus.dc_ready;
    assign resp   = reset_n && (state == WAIT) && bus.dc_rvalid;

    always_comb begin
        bus.dc_read  = issue;
        bus.dc_trans = 1'b0;
        bus.dc_addr  = '0;
        if (issue) begin
            unique case (cur)
                OWN_MEM1: bus.dc_addr = {3'b000, bus.mem1_addr};
                OWN_FE1:  bus.dc_addr = {3'b000, bus.fe1_addr};
                OWN_MEM0: begin
                    bus.dc_addr  = bus.mem0_addr;
                    bus.dc_trans = bus.mem0_trans;
                end
                default: ;
            endcase
        end
    end

    assign bus.dc_asid     = bus.satp_asid;
    assign bus.mem1_gnt    = accept && (cur == OWN_MEM1);
    assign bus.fe1_gnt     = accept && (cur == OWN_FE1);
    assign bus.mem0_gnt    = accept && (cur == OWN_MEM0);
    assign bus.mem1_rvalid = resp && (owner == OWN_MEM1);
    assign bus.fe1_rvalid  = resp && (owner == OWN_FE1);
    assign bus.mem0_rvalid = resp && (owner == OWN_MEM0);

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (winner != OWN_NONE) begin
                    owner <= winner;
                    state <= bus.dc_ready ? WAIT : ISSUE;
                end
                ISSUE: if (bus.dc_ready) state <= WAIT;
                WAIT: if (bus.dc_rvalid) begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
                default: state <= IDLE;
            endcase
            if (bus.mem0_gnt)
                starve_cnt <= '0;
            else if (state == IDLE && bus.mem0_req &&
                     winner != OWN_MEM0 && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign own_req = (owner == OWN_MEM1 && bus.mem1_req) ||
                     (owner == OWN_FE1  && bus.fe1_req)  ||
                     (owner == OWN_MEM0 && bus.mem0_req);

    assert property (@(posedge clk_core) disable iff (!reset_n)
        $onehot0({bus.mem1_gnt, bus.fe1_gnt, bus.mem0_gnt}));
    assert property (@(posedge clk_core) disable iff (!reset_n)
        $onehot0({bus.mem1_rvalid, bus.fe1_rvalid, bus.mem0_rvalid}));
    assert property (@(posedge clk_core) disable iff (!reset_n)
        (state == ISSUE) |-> own_req);
    // a stray response is harmless to the FSM, so it is only reported
    assert property (@(posedge clk_core) disable iff (!reset_n)
        bus.dc_rvalid |-> (state == WAIT))
        else $warning("dc_rvalid dropped outside WAIT");
endmodule

// File: tb/tb_dcache_read_arbiter.sv
// Directed and random checks of dcache_read_arbiter against a
// transaction-level model of the arbitration rules.
module tb_dcache_read_arbiter;
    localparam int LIM = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_read_arbiter_if bus ();

    dcache_read_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
        .clk_core(clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // requester index: 0=mem1, 1=fe1, 2=mem0
    logic [2:0]  rq;
    logic [29:0] ad [3];
    logic        m0t;

    bit busy;
    int lock;
    int own;
    int starve;
    bit rr;
    int rvw;

    logic [2:0]  e_gnt, e_rv, o_gnt, o_rv;
    logic        e_read, e_trans, o_read, o_trans;
    logic [29:0] e_addr, o_addr;
    logic [2:0]  gs [4];
    bit          ok;
    bit          rvv;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.mem1_req   = rq[0];
        bus.mem1_addr  = ad[0][26:0];
        bus.fe1_req    = rq[1];
        bus.fe1_addr   = ad[1][26:0];
        bus.mem0_req   = rq[2];
        bus.mem0_addr  = ad[2];
        bus.mem0_trans = m0t;
    endtask

    task automatic model_reset();
        busy = 0; lock = -1; own = 0; starve = 0; rr = 0;
    endtask

    function automatic int pick();
        bit aged;
        aged = (LIM != 0) && (starve >= LIM);
        if (aged && rq[2]) return 2;
`ifdef DCARB_RR_EN
        if (rq[0] && rq[1]) return rr ? 1 : 0;
`endif
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        if (rq[2]) return 2;
        return -1;
    endfunction

    task automatic tick(input bit rdy, input bit rv);
        int win;
        logic [8:0] asid;
        asid = 9'($urandom);
        bus.satp_asid = asid;
        bus.dc_ready  = rdy;
        bus.dc_rvalid = rv;
        drive();
        #2;
        e_gnt = '0; e_rv = '0; e_read = 0; e_trans = 0; e_addr = '0;
        if (busy) begin
            if (rv) begin
                e_rv[own] = 1'b1;
                busy = 0;
            end
        end else begin
            win = (lock >= 0) ? lock : pick();
            if (win >= 0) begin
                e_read  = 1'b1;
                e_addr  = ad[win];
                e_trans = (win == 2) ? m0t : 1'b0;
                if (lock < 0 && rq[2] && win != 2 && starve < 15)
                    starve++;
                if (rdy) begin
                    e_gnt[win] = 1'b1;
                    busy = 1; own = win; lock = -1;
                    if (win == 2) starve = 0;
`ifdef DCARB_RR_EN
                    else rr = !rr;
`endif
                end else begin
                    lock = win;
                end
            end
        end
        o_gnt   = {bus.mem0_gnt, bus.fe1_gnt, bus.mem1_gnt};
        o_rv    = {bus.mem0_rvalid, bus.fe1_rvalid, bus.mem1_rvalid};
        o_read  = bus.dc_read;
        o_addr  = bus.dc_addr;
        o_trans = bus.dc_trans;
        chk("gnt", o_gnt, e_gnt);
        chk("rvalid", o_rv, e_rv);
        chk("dc_read", o_read, e_read);
        chk("dc_addr", o_addr, e_addr);
        chk("dc_trans", o_trans, e_trans);
        chk("dc_asid", bus.dc_asid, asid);
        for (int i = 0; i < 3; i++)
            if (e_gnt[i]) rq[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_gnt"},
            {bus.mem0_gnt, bus.fe1_gnt, bus.mem1_gnt}, 0);
        chk({tag, "_rvalid"},
            {bus.mem0_rvalid, bus.fe1_rvalid, bus.mem1_rvalid}, 0);
        chk({tag, "_read"}, bus.dc_read, 0);
        chk({tag, "_trans"}, bus.dc_trans, 0);
        chk({tag, "_addr"}, bus.dc_addr, 0);
    endtask

    task automatic drain(output bit done);
        int g;
        g = 0;
        while ((rq != 0 || busy || lock >= 0) && g < 60) begin
            tick(1'b1, busy);
            g++;
        end
        done = (rq == 0) && !busy && (lock < 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rq = '0; m0t = 0;
        for (int i = 0; i < 3; i++) ad[i] = '0;
        bus.satp_asid = '0; bus.dc_ready = 0; bus.dc_rvalid = 0;
        drive();
        model_reset();
        #2;
        rq[0] = 1; ad[0] = 30'h0000_1234;
        drive();
        #1;
        chk_zero("reset");
        rq[0] = 0;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1;

        // single translated mem0 read
        rq[2] = 1; ad[2] = 30'h0400_0010; m0t = 1;
        tick(1, 0);
        chk("t1_gnt", o_gnt, 3'b100);
        chk("t1_trans", o_trans, 1);
        chk("t1_addr", o_addr, 30'h0400_0010);
        tick(0, 0);
        chk("t1_no_early_rv", o_rv, 0);
        tick(0, 1);
        chk("t1_rv", o_rv, 3'b100);
        rq[1] = 1; ad[1] = 30'h0000_0abc;
        tick(1, 0);
        chk("t1_idle_again", o_gnt, 3'b010);
        tick(0, 1);

        // three simultaneous requesters
        rq = 3'b111; m0t = 1;
        ad[0] = 30'h0111_1111; ad[1] = 30'h0222_2222;
        ad[2] = 30'h3333_3333;
        tick(1, 0);
        chk("t2_first", o_gnt, 3'b001);
        chk("t2_walk_trans", o_trans, 0);
        tick(1, 1);
        chk("t2_bubble", o_read, 0);
        tick(1, 0);
        chk("t2_second", o_gnt, 3'b010);
        tick(1, 1);
        tick(1, 0);
        chk("t2_third", o_gnt, 3'b100);
        tick(1, 1);

        // owner stays locked while dcache stalls
        rq[1] = 1; ad[1] = 30'h0055_aa55;
        tick(0, 0);
        rq[0] = 1; ad[0] = 30'h0066_0066;
        tick(0, 0);
        chk("t3_addr_c1", o_addr, 30'h0055_aa55);
        tick(0, 0);
        chk("t3_addr_c2", o_addr, 30'h0055_aa55);
        tick(1, 0);
        chk("t3_fe1_gnt", o_gnt, 3'b010);
        tick(0, 1);
        tick(1, 0);
        chk("t3_mem1_next", o_gnt, 3'b001);
        tick(0, 1);

        // mem0 ageing against continuous walks
        rq[2] = 1; ad[2] = 30'h1abc_def0; m0t = 0;
        for (int k = 0; k < 4; k++) begin
            rq[0] = 1; rq[1] = 1; rq[2] = 1;
            tick(1, 0);
            gs[k] = o_gnt;
            tick(1, 1);
        end
        chk("t4_aged_third", gs[2], 3'b100);
        chk("t4_cleared", gs[3][2], 0);
        drain(ok);
        chk("t4_drain", ok, 1);

        // reset in the middle of WAIT
        rq[2] = 1; ad[2] = 30'h0bad_0bad;
        tick(1, 0);
        rst_n = 0;
        bus.dc_rvalid = 1;
        #1;
        chk_zero("t5_reset");
        model_reset();
        rq = '0;
        drive();
        @(posedge clk);
        #1;
        bus.dc_rvalid = 0;
        rst_n = 1;
        tick(0, 1);
        chk("t5_stray_rv", o_rv, 0);

        // walker slot sharing
        ad[0] = 30'h0000_0101; ad[1] = 30'h0000_0202;
        for (int k = 0; k < 4; k++) begin
            rq[0] = 1; rq[1] = 1;
            tick(1, 0);
`ifdef DCARB_RR_EN
            chk("t6_rr_order", o_gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
`else
            chk("t6_fixed_order", o_gnt, 3'b001);
`endif
            tick(1, 1);
        end
        drain(ok);
        chk("t6_drain", ok, 1);

        // random traffic
        rvw = 0;
        for (int c = 0; c < 400; c++) begin
            rvv = 0;
            if (busy) begin
                if (rvw <= 1) rvv = 1;
                else rvw--;
            end
            for (int i = 0; i < 3; i++) begin
                if (!rq[i] && $urandom_range(0, 99) < 30) begin
                    rq[i] = 1;
                    if (i == 2) begin
                        ad[i] = 30'($urandom);
                        m0t = 1'($urandom);
                    end else begin
                        ad[i] = {3'b000, 27'($urandom)};
                    end
                end
            end
            tick($urandom_range(0, 99) < 70, rvv);
            if (e_gnt != 0) rvw = $urandom_range(1, 3);
        end
        drain(ok);
        chk("rand_drain", ok, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
